// File: rtl/paillier_l_function_pkg.sv
// Shared types and widths for the Paillier L-function and its neighbouring
// modular-inverse stage.
package paillier_pkg;

  localparam int PAILLIER_K = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } l_state_t;

endpackage

// File: rtl/paillier_l_function_if.sv
// Operand/result bundle for paillier_l_function.
// Optional macro PAILLIER_L_REM_CHECK_EN adds the rem_nz result flag.
interface paillier_l_function_if #(
  parameter int K = paillier_pkg::PAILLIER_K
);
  // Handshake: an operand transfers on a rising edge where valid_in and ready
  // are both 1; x and n are sampled only then. valid_out is a single-cycle
  // pulse with no back-pressure, and q/err (and rem_nz) hold until the next one.
  logic           valid_in;
  logic           ready;
  logic [2*K-1:0] x;
  logic [K-1:0]   n;
  logic [K-1:0]   q;
  logic           valid_out;
  logic           err;
`ifdef PAILLIER_L_REM_CHECK_EN
  logic           rem_nz;

  modport master (output valid_in, x, n,
                  input  ready, q, valid_out, err, rem_nz);
  modport slave  (input  valid_in, x, n,
                  output ready, q, valid_out, err, rem_nz);
`else
  modport master (output valid_in, x, n,
                  input  ready, q, valid_out, err);
  modport slave  (input  valid_in, x, n,
                  output ready, q, valid_out, err);
`endif

endinterface

// File: rtl/paillier_l_function_l_div_step.sv
// One combinational radix-2 restoring division step: shift in a dividend bit,
// conditionally subtract the divisor, emit the quotient bit.
module l_div_step #(
  parameter int K = 128
) (
  input  logic [K:0]   rem,
  input  logic         bit_in,
  input  logic [K-1:0] n,
  output logic [K:0]   rem_next,
  output logic         q_bit
);

  logic [K:0] t;
  logic       unused_rem_msb;

  // A remainder below n never uses bit K, so it is shifted out.
  assign unused_rem_msb = rem[K];
  assign t              = {rem[K-1:0], bit_in};
  assign q_bit          = (t >= {1'b0, n});
  assign rem_next       = q_bit ? (t - {1'b0, n}) : t;

endmodule

// File: rtl/paillier_l_function.sv
// Paillier L(x) = (x - 1) / n by bit-serial restoring division, K+3 cycles per op.
// Optional macro PAILLIER_L_REM_CHECK_EN reports a nonzero final remainder.
module paillier_l_function
  import paillier_pkg::*;
#(
  parameter  int K     = PAILLIER_K,
  localparam int CNT_W = $clog2(K) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  paillier_l_function_if.slave   bus,
  output l_state_t               dbg_state
);

  l_state_t       state, state_next;
  logic [2*K-1:0] x_r;
  logic [K-1:0]   n_r;
  logic [K:0]     rem_r;
  logic [K-1:0]   dlo_r;
  logic [K-1:0]   q_r;
  logic [CNT_W-1:0] cnt_r;
  logic           err_r;
  logic [K-1:0]   q_o;
  logic           err_o;
  logic           valid_o;

  logic [2*K-1:0] d;
  logic           op_err;
  logic           last_step;
  logic [K:0]     rem_next;
  logic           q_bit;
  logic [K-1:0]   q_next;

  assign d         = x_r - {{(2*K-1){1'b0}}, 1'b1};
  assign op_err    = (n_r == '0) || (x_r == '0);
  assign last_step = (cnt_r == CNT_W'(1));
  assign q_next    = (q_r << 1) | K'(q_bit);

  l_div_step #(.K(K)) u_step (
    .rem      (rem_r),
    .bit_in   (dlo_r[K-1]),
    .n        (n_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.valid_in) state_next = LOAD;
      LOAD: state_next = op_err ? DONE : DIV;
      DIV:  if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers are loaded on the edge that enters DONE, so valid_out
  // is high exactly for the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= '0;
      n_r     <= '0;
      rem_r   <= '0;
      dlo_r   <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      q_o     <= '0;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            x_r <= bus.x;
            n_r <= bus.n;
          end
        end
        LOAD: begin
          // x < n^2 keeps the upper half of x-1 below n, so it seeds the remainder.
          rem_r <= {1'b0, d[2*K-1:K]};
          dlo_r <= d[K-1:0];
          cnt_r <= CNT_W'(K);
          q_r   <= '0;
          err_r <= op_err;
          if (op_err) begin
            q_o     <= '0;
            err_o   <= 1'b1;
            valid_o <= 1'b1;
          end
        end
        DIV: begin
          rem_r <= rem_next;
          dlo_r <= dlo_r << 1;
          q_r   <= q_next;
          cnt_r <= cnt_r - CNT_W'(1);
          if (last_step) begin
            q_o     <= q_next;
            err_o   <= err_r;
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PAILLIER_L_REM_CHECK_EN
  logic rem_nz_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_nz_o <= 1'b0;
    end else if (state == LOAD && op_err) begin
      rem_nz_o <= 1'b0;
    end else if (state == DIV && last_step) begin
      rem_nz_o <= (rem_next != '0);
    end
  end

  assign bus.rem_nz = rem_nz_o;
`endif

  assign bus.ready     = (state == IDLE);
  assign bus.q         = q_o;
  assign bus.err       = err_o;
  assign bus.valid_out = valid_o;
  assign dbg_state     = state;

endmodule

// File: tb/tb_paillier_l_function.sv
// Directed bench for paillier_l_function at K=8 (n=13 family plus wide-n cases).
module tb_paillier_l_function;
  import paillier_pkg::*;

  localparam int K = 8;

  logic     clk = 1'b0;
  logic     rst;
  l_state_t dbg_state;

  always #5 clk = ~clk;

  paillier_l_function_if #(.K(K)) bus ();

  paillier_l_function #(.K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string          name;
    logic [2*K-1:0] x;
    logic [K-1:0]   n;
    logic [K-1:0]   q;
    logic           err;
    logic           rem_nz;
    int             lat;
    bit             chk_q;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the result pulse.
  task automatic run_op(input vec_t v);
    int got;
    for (int c = 0; c < 50 && bus.ready !== 1'b1; c++) @(negedge clk);
    check({v.name, "_ready_before"}, 32'(bus.ready), 1);
    bus.valid_in = 1'b1;
    bus.x        = v.x;
    bus.n        = v.n;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
    got = -1;
    for (int cyc = 1; cyc <= 40 && got < 0; cyc++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) got = cyc;
    end
    check({v.name, "_latency"}, 32'(got), 32'(v.lat));
    if (v.chk_q) check({v.name, "_q"}, 32'(bus.q), 32'(v.q));
    check({v.name, "_err"}, 32'(bus.err), 32'(v.err));
`ifdef PAILLIER_L_REM_CHECK_EN
    if (v.chk_q) check({v.name, "_rem_nz"}, 32'(bus.rem_nz), 32'(v.rem_nz));
`endif
    @(negedge clk);
    check({v.name, "_pulse_single"}, 32'(bus.valid_out), 0);
    check({v.name, "_ready_after"}, 32'(bus.ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, pulses;

    //          name        x       n    q    err   rem_nz lat  chk_q
    vecs[0] = '{"x66",      66,     13,  5,   1'b0, 1'b0, 10,  1'b1};
    vecs[1] = '{"x1",       1,      13,  0,   1'b0, 1'b0, 10,  1'b1};
    vecs[2] = '{"x168",     168,    13,  12,  1'b0, 1'b1, 10,  1'b1};
    vecs[3] = '{"n0",       50,     0,   0,   1'b1, 1'b0, 2,   1'b1};
    vecs[4] = '{"x0",       0,      13,  0,   1'b1, 1'b0, 2,   1'b1};
    vecs[5] = '{"x39999",   39999,  200, 199, 1'b0, 1'b1, 10,  1'b1};
    vecs[6] = '{"x65024",   65024,  255, 254, 1'b0, 1'b1, 10,  1'b1};
    vecs[7] = '{"x_over",   16'h0F00, 13, 0,  1'b0, 1'b0, 10,  1'b0};
    vecs[8] = '{"x144",     144,    13,  11,  1'b0, 1'b0, 10,  1'b1};

    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.x        = '0;
    bus.n        = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 1);
    check("reset_valid_out", 32'(bus.valid_out), 0);
    check("reset_q", 32'(bus.q), 0);
    check("reset_err", 32'(bus.err), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
`ifdef PAILLIER_L_REM_CHECK_EN
    check("reset_rem_nz", 32'(bus.rem_nz), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Back-to-back: valid_in stays high; the second operand (27) is only taken
    // once ready returns after the first pulse.
    bus.valid_in = 1'b1;
    bus.x        = 66;
    bus.n        = 13;
    @(posedge clk);
    #1 bus.x = 27;
    first  = -1;
    second = -1;
    pulses = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          check("b2b_first_q", 32'(bus.q), 5);
        end else if (second < 0) begin
          second = cyc;
          check("b2b_second_q", 32'(bus.q), 2);
          bus.valid_in = 1'b0;
        end
      end
      if (cyc == 15) begin
        check("b2b_q_hold", 32'(bus.q), 5);
        check("b2b_busy", 32'(bus.ready), 0);
      end
    end
    bus.valid_in = 1'b0;
    check("b2b_first_cycle", 32'(first), 10);
    check("b2b_second_cycle", 32'(second), 21);
    check("b2b_pulse_count", 32'(pulses), 2);
    repeat (2) @(negedge clk);

    // Reset in the middle of DIV aborts without a result pulse.
    bus.valid_in = 1'b1;
    bus.x        = 66;
    bus.n        = 13;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_div", 32'(dbg_state), 32'(DIV));
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus.ready), 1);
    check("abort_q", 32'(bus.q), 0);
    check("abort_valid_out", 32'(bus.valid_out), 0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 0);
    run_op(vecs[8]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
